// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared state encoding, coin codes and default coin values for the vending datapath
package vending_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_CHANGE   = 2'd2
  } state_t;

  localparam logic [1:0] COIN_5C  = 2'b00;
  localparam logic [1:0] COIN_10C = 2'b01;
  localparam logic [1:0] COIN_25C = 2'b10;
  localparam logic [1:0] COIN_BAD = 2'b11;

  localparam int DEF_COIN0_VAL = 1;
  localparam int DEF_COIN1_VAL = 2;
  localparam int DEF_COIN2_VAL = 5;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// rtl/ripple_carry_adder.sv - N-bit ripple-carry adder built from a chain of full_adder cells
module ripple_carry_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/coin_credit_accumulator.sv
// rtl/coin_credit_accumulator.sv - coin credit register with vend/refund FSM and registered change output
module coin_credit_accumulator
  import vending_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200,
  parameter int COIN0_VAL  = DEF_COIN0_VAL,
  parameter int COIN1_VAL  = DEF_COIN1_VAL,
  parameter int COIN2_VAL  = DEF_COIN2_VAL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic [CREDIT_W-1:0] price,
  input  logic                buy,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                insufficient,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                busy
);

  state_t              state, state_n;
  logic [CREDIT_W-1:0] credit_n, change_n, coin_val, add_sum, diff;
  logic                add_cout, sub_cout, coin_bad;
  logic                disp_n, ins_n, rej_n, cv_n, busy_n;

  always_comb begin
    coin_val = '0;
    coin_bad = 1'b0;
    case (coin_type)
      COIN_5C:  coin_val = CREDIT_W'(COIN0_VAL);
      COIN_10C: coin_val = CREDIT_W'(COIN1_VAL);
      COIN_25C: coin_val = CREDIT_W'(COIN2_VAL);
      default:  coin_bad = 1'b1;
    endcase
  end

  ripple_carry_adder #(.N(CREDIT_W)) u_add (
    .a    (credit),
    .b    (coin_val),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // credit - price as credit + ~price + 1; carry-out set means credit >= price
  ripple_carry_adder #(.N(CREDIT_W)) u_sub (
    .a    (credit),
    .b    (~price),
    .cin  (1'b1),
    .sum  (diff),
    .cout (sub_cout)
  );

  always_comb begin
    state_n  = state;
    credit_n = credit;
    change_n = change_amount;
    disp_n   = 1'b0;
    ins_n    = 1'b0;
    rej_n    = 1'b0;
    case (state)
      ST_ACCUM: begin
        if (cancel) begin
          rej_n = coin_valid;
          if (credit != '0) begin
            change_n = credit;
            credit_n = '0;
            state_n  = ST_CHANGE;
          end
        end else if (buy) begin
          rej_n = coin_valid;
          if (price != '0 && sub_cout) begin
            change_n = diff;
            credit_n = '0;
            disp_n   = 1'b1;
            state_n  = ST_DISPENSE;
          end else begin
            ins_n = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_bad || add_cout || add_sum > CREDIT_W'(MAX_CREDIT))
            rej_n = 1'b1;
          else
            credit_n = add_sum;
        end
      end
      ST_DISPENSE: begin
        rej_n   = coin_valid;
        state_n = (change_amount != '0) ? ST_CHANGE : ST_ACCUM;
      end
      ST_CHANGE: begin
        rej_n = coin_valid;
        if (change_ack) begin
          change_n = '0;
          state_n  = ST_ACCUM;
        end
      end
      default: state_n = ST_ACCUM;
    endcase
    // status outputs are registered copies of the next state
    cv_n   = (state_n == ST_CHANGE);
    busy_n = (state_n != ST_ACCUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ACCUM;
      credit        <= '0;
      change_amount <= '0;
      dispense      <= 1'b0;
      insufficient  <= 1'b0;
      coin_reject   <= 1'b0;
      change_valid  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      credit        <= credit_n;
      change_amount <= change_n;
      dispense      <= disp_n;
      insufficient  <= ins_n;
      coin_reject   <= rej_n;
      change_valid  <= cv_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// tb/tb_coin_credit_accumulator.sv - scoreboard bench for coin_credit_accumulator
module tb_coin_credit_accumulator;

  logic       clk = 1'b0;
  logic       rst, coin_valid, buy, cancel, change_ack;
  logic [1:0] coin_type;
  logic [7:0] price, credit, change_amount;
  logic       dispense, insufficient, coin_reject, change_valid, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       disp;
    logic       ins;
    logic       rej;
    logic       cv;
    logic [7:0] credit;
    logic [7:0] chg;
    logic       busy;
  } ev_t;

  ev_t  exp_q[$];
  logic mon_en = 1'b0;
  logic [7:0] prev_credit;
  logic prev_cv, prev_busy;

  always #5 clk = ~clk;

  coin_credit_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_type     (coin_type),
    .price         (price),
    .buy           (buy),
    .cancel        (cancel),
    .change_ack    (change_ack),
    .credit        (credit),
    .dispense      (dispense),
    .insufficient  (insufficient),
    .coin_reject   (coin_reject),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .busy          (busy)
  );

  task automatic expect_ev(input logic d, input logic i, input logic r, input logic cv,
                           input int cr, input int ch, input logic b);
    ev_t e;
    e.disp = d; e.ins = i; e.rej = r; e.cv = cv;
    e.credit = 8'(cr); e.chg = 8'(ch); e.busy = b;
    exp_q.push_back(e);
  endtask

  // Drive a one-cycle strobe on the selected inputs, then idle one cycle.
  task automatic strobe(input logic cvld, input logic [1:0] ct, input logic b,
                        input logic c, input logic ack, input logic r);
    @(posedge clk); #1;
    coin_valid = cvld; coin_type = ct; buy = b; cancel = c; change_ack = ack; rst = r;
    @(posedge clk); #1;
    coin_valid = 1'b0; buy = 1'b0; cancel = 1'b0; change_ack = 1'b0; rst = 1'b0;
  endtask

  task automatic coin(input logic [1:0] ct);
    strobe(1'b1, ct, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: any pulse or change of credit/change_valid/busy is an event
  always @(negedge clk) begin
    ev_t got, want;
    if (mon_en) begin
      if (dispense || insufficient || coin_reject || change_valid != prev_cv ||
          credit != prev_credit || busy != prev_busy) begin
        got.disp = dispense; got.ins = insufficient; got.rej = coin_reject;
        got.cv = change_valid; got.credit = credit; got.chg = change_amount; got.busy = busy;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event t=%0t: got disp=%0b ins=%0b rej=%0b cv=%0b credit=%0d chg=%0d busy=%0b, want no event",
                   $time, got.disp, got.ins, got.rej, got.cv, got.credit, got.chg, got.busy);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL event t=%0t: got disp=%0b ins=%0b rej=%0b cv=%0b credit=%0d chg=%0d busy=%0b, want disp=%0b ins=%0b rej=%0b cv=%0b credit=%0d chg=%0d busy=%0b",
                     $time, got.disp, got.ins, got.rej, got.cv, got.credit, got.chg, got.busy,
                     want.disp, want.ins, want.rej, want.cv, want.credit, want.chg, want.busy);
          end
        end
      end
    end
    prev_credit = credit;
    prev_cv     = change_valid;
    prev_busy   = busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; price = 8'd0;
    buy = 1'b0; cancel = 1'b0; change_ack = 1'b0;
    idle(3);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({credit, change_amount, dispense, insufficient, coin_reject, change_valid, busy} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got credit=%0d chg=%0d disp=%0b ins=%0b rej=%0b cv=%0b busy=%0b, want all 0",
               credit, change_amount, dispense, insufficient, coin_reject, change_valid, busy);
    end
    mon_en = 1'b1;

    // cancel with zero credit does nothing
    strobe(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    // 25c, 25c, 10c -> 5, 10, 12
    expect_ev(0,0,0,0, 5,0,0);  coin(2'b10);
    expect_ev(0,0,0,0,10,0,0);  coin(2'b10);
    expect_ev(0,0,0,0,12,0,0);  coin(2'b01);

    // buy at 10 with 12: dispense, then change 2 held until ack
    price = 8'd10;
    expect_ev(1,0,0,0,0,2,1);
    expect_ev(0,0,0,1,0,2,1);
    strobe(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    expect_ev(0,0,0,0,0,0,0);
    strobe(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // credit 3, insufficient for 10 and for price 0
    expect_ev(0,0,0,0,2,0,0);  coin(2'b01);
    expect_ev(0,0,0,0,3,0,0);  coin(2'b00);
    expect_ev(0,1,0,0,3,0,0);
    strobe(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    price = 8'd0;
    expect_ev(0,1,0,0,3,0,0);
    strobe(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // fill to 198 with 25c coins
    for (int k = 1; k <= 39; k++) begin
      expect_ev(0,0,0,0,3 + 5*k,0,0);
      coin(2'b10);
    end
    expect_ev(0,0,1,0,198,0,0);  coin(2'b10);
    expect_ev(0,0,1,0,198,0,0);  coin(2'b11);
    expect_ev(0,0,0,0,200,0,0);  coin(2'b01);
    expect_ev(0,0,1,0,200,0,0);  coin(2'b00);

    // cancel refunds full 200
    expect_ev(0,0,0,1,0,200,1);
    strobe(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ev(0,0,0,0,0,0,0);
    strobe(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // credit 7, cancel with a coin in the same cycle
    expect_ev(0,0,0,0,5,0,0);  coin(2'b10);
    expect_ev(0,0,0,0,7,0,0);  coin(2'b01);
    expect_ev(0,0,1,1,0,7,1);
    strobe(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_ev(0,0,1,1,0,7,1);  coin(2'b00);
    strobe(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_ev(0,0,0,0,0,0,0);
    strobe(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

    // buy and coin together with no credit
    price = 8'd5;
    expect_ev(0,1,1,0,0,0,0);
    strobe(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

    // exact price: dispense then straight back to ACCUM
    expect_ev(0,0,0,0, 5,0,0);  coin(2'b10);
    expect_ev(0,0,0,0,10,0,0);  coin(2'b10);
    price = 8'd10;
    expect_ev(1,0,0,0,0,0,1);
    expect_ev(0,0,0,0,0,0,0);
    strobe(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // reset during CHANGE clears everything
    expect_ev(0,0,0,0,5,0,0);  coin(2'b10);
    expect_ev(0,0,0,1,0,5,1);
    strobe(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_ev(0,0,0,0,0,0,0);
    strobe(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending events, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
